// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, dispatcher state encoding and
// instruction field slices used by the front-end sequencer and the execution FSMs.
package cpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALUI   = 4'h1;
    localparam logic [3:0] OP_ALU    = 4'h2;
    localparam logic [3:0] OP_LOAD   = 4'h3;
    localparam logic [3:0] OP_STORE  = 4'h4;
    localparam logic [3:0] OP_JUMP   = 4'h5;
    localparam logic [3:0] OP_BRANCH = 4'h6;
    localparam logic [3:0] OP_MOVE   = 4'h7;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH_A = 3'd0,
        ST_FETCH_R = 3'd1,
        ST_DECODE  = 3'd2,
        ST_SKIP    = 3'd3,
        ST_EXEC    = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_HALT    = 3'd6
    } disp_state_t;

    function automatic logic [3:0] instr_opcode(input logic [15:0] word);
        return word[15:12];
    endfunction

    function automatic logic [5:0] instr_param1(input logic [15:0] word);
        return word[11:6];
    endfunction

    function automatic logic [5:0] instr_param2(input logic [15:0] word);
        return word[5:0];
    endfunction

endpackage

// File: rtl/exec_watchdog.sv
// EXEC-phase watchdog: 8-bit cycle counter with clear/enable, flags expiry in
// the LIMIT-th enabled cycle. Only built when DISPATCH_WDOG_EN is defined.
`ifdef DISPATCH_WDOG_EN
module exec_watchdog #(
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (enable && !expire) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds (EXEC cycle number - 1), so expiry lands in cycle LIMIT
    assign expire = enable && (cnt == 8'(LIMIT - 1));

endmodule
`endif

// File: rtl/instr_fetch_dispatch.sv
// Front-end sequencer: fetch a word into IR, decode, dispatch to the execution
// FSMs and flush them. Optional EXEC watchdog enabled by DISPATCH_WDOG_EN.
module instr_fetch_dispatch #(
    parameter logic [15:0] OP_VALID_MASK = 16'h00FF,
    parameter logic [3:0]  OP_HALT       = 4'hF,
    parameter int          TIMEOUT_CYC   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rdy,
    input  logic [15:0] mem_data,
    input  logic        exec_done,
    output logic        PC_out,
    output logic        MAR_in,
    output logic        mem_rd,
    output logic        PC_inc_skip,
    output logic [15:0] fullBitNum,
    output logic        illegal_op,
    output logic        halted,
    output logic [15:0] instr_cnt,
    output logic        exec_timeout,
    output logic [2:0]  state_dbg
);
    import cpu_pkg::*;

    // Handshake: mem_rd is held high through FETCH_R; a word is accepted only
    // in a cycle where mem_rd and mem_rdy are both high. exec_done is accepted
    // only while fullBitNum is non-zero (EXEC), from its first cycle onward.

    disp_state_t state, state_nxt;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic        run;
    logic        wdog_expire;

    assign opcode    = instr_opcode(ir);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH_A;
            ir        <= 16'h0000;
            run       <= 1'b0;
            instr_cnt <= 16'h0000;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (state == ST_FETCH_R && mem_rdy) begin
                ir <= mem_data;
            end
            if (state == ST_EXEC && exec_done) begin
                instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        PC_out       = 1'b0;
        MAR_in       = 1'b0;
        mem_rd       = 1'b0;
        PC_inc_skip  = 1'b0;
        fullBitNum   = 16'h0000;
        illegal_op   = 1'b0;
        halted       = 1'b0;
        exec_timeout = 1'b0;
        case (state)
            ST_FETCH_A: begin
                // the first cycle out of reset keeps every output low
                if (run) begin
                    PC_out    = 1'b1;
                    MAR_in    = 1'b1;
                    state_nxt = ST_FETCH_R;
                end
            end
            ST_FETCH_R: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else if (opcode == OP_NOP) begin
                    state_nxt = ST_SKIP;
                end else if (!OP_VALID_MASK[opcode]) begin
                    illegal_op = 1'b1;
                    state_nxt  = ST_SKIP;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_SKIP: begin
                PC_inc_skip = 1'b1;
                state_nxt   = ST_FLUSH;
            end
            ST_EXEC: begin
                fullBitNum = ir;
                // completion in the expiry cycle takes priority over the timeout
                if (exec_done) begin
                    state_nxt = ST_FLUSH;
                end else if (wdog_expire) begin
                    exec_timeout = 1'b1;
                    state_nxt    = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_FETCH_A;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = ST_FETCH_A;
            end
        endcase
    end

`ifdef DISPATCH_WDOG_EN
    exec_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_exec_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_EXEC),
        .enable (state == ST_EXEC),
        .expire (wdog_expire)
    );
`else
    logic [7:0] unused_wdog_limit;
    assign unused_wdog_limit = 8'(TIMEOUT_CYC);
    assign wdog_expire       = 1'b0;
`endif

endmodule
